lsu_axi_ctrl: RTL and testbench
===============================

Name: lsu_axi_ctrl

Overview:
Sequences one data-memory access per accepted LSU request over AXI4-Lite master channels (AR/R, AW/W/B) toward the data SRAM.
- Consumes the precomputed address, offset, store data and byte strobe from the LSU address-preparation stage.
- Aligns store data to the strobe lanes.
- Extracts and extends load data.
- Returns a result to the writeback stage via a valid/ready handshake.
- Sits between the EXU LSU front end and the data-side AXI interconnect.

Parameters:
TIMEOUT, 255, max cycles waiting on any single AXI handshake before aborting with err_o; 0 disables the timeout.

Ports:
clk  in  1  system clock
rst  in  1  asynchronous active-high reset (`RST_ENABLE` = 1)
valid_i  in  1  request valid from EXU
ready_o  out  1  controller can accept a request
inst_type_i  in  `INST_TYPE_BUS`  `INST_LOAD` / `INST_STORE` / other
lsu_op_i  in  `LSU_OP_BUS`  LB/LBU/LH/LHU/LW/SB/SH/SW code
araddr_i  in  32  load byte address
roff_i  in  32  load byte offset within word (0..3)
awaddr_i  in  32  store byte address
wdata_i  in  32  store data, unshifted (LSB-aligned)
wstrb_i  in  8  store byte strobe; bits [7:4] ignored
valid_o  out  1  result valid to WBU
ready_i  in  1  WBU accepts result
rdata_o  out  32  extended load data; 0 for store/other
err_o  out  1  qualifies valid_o: nonzero RESP or timeout
arvalid_o / arready_i / araddr_o(32)  AXI read address
rvalid_i / rready_o / rdata_i(32) / rresp_i(2)  AXI read data
awvalid_o / awready_i / awaddr_o(32)  AXI write address
wvalid_o / wready_i / wdata_o(32) / wstrb_o(4)  AXI write data
bvalid_i / bready_o / bresp_i(2)  AXI write response

Behaviour:
- Reset (async, rst=1): state IDLE; all outputs 0, including ready_o. Any in-flight transaction is abandoned and all AXI valids/readies drop immediately.
- States: IDLE, RADDR, RDATA, WREQ, WRESP, DONE.
- IDLE: ready_o=1. On valid_i&ready_o, latch all inputs:
  - load → RADDR
  - store → WREQ
  - other → DONE with rdata_o=0, err_o=0
- RADDR: arvalid_o=1, araddr_o = araddr & 0xFFFF_FFFC. On arready_i → RDATA.
- RDATA: rready_o=1. On rvalid_i:
  - shifted = rdata_i >> (roff[1:0]*8)
  - LB: sext byte; LBU: zext byte; LH: sext half; LHU: zext half; LW: full word
  - err_o = (rresp_i != 0)
  - → DONE
- WREQ: awvalid_o and wvalid_o assert together.
  - awaddr_o = aligned awaddr.
  - wdata_o = wdata << (awaddr[1:0]*8).
  - wstrb_o = wstrb[3:0].
  - Each valid drops independently the cycle after its own handshake; simultaneous handshakes are allowed.
  - → WRESP once both AW and W are done.
- WRESP: bready_o=1. On bvalid_i, err_o = (bresp_i != 0), rdata_o=0 → DONE.
- DONE: valid_o=1; rdata_o/err_o held stable until valid_o&ready_i → IDLE. The next request cannot be accepted in the same cycle; minimum issue interval is 1 request per 2 cycles for non-memory ops.
- Latency (zero-wait slave): load is 3 cycles from accept to valid_o; store is 3 cycles.
- AXI rule: valids are never dropped before their handshake unless reset or timeout occurs.
- Timeout: a counter resets on every state entry and counts while in RADDR/RDATA/WREQ/WRESP. At TIMEOUT it forces DONE with err_o=1, rdata_o=0, and drops all AXI valids/readies.
- Zero-strobe store (misaligned op upstream): still issued with wstrb_o=0; no special case.
- Outputs are registered; AXI outputs are state-decoded from registered state.

Test Plan:
1. Reset mid-read: assert rst while arvalid_o=1 → arvalid_o=0 the same cycle; after release, state IDLE and ready_o=1.
2. LB, araddr 0x8000_0003, roff 3, slave returns 0x80FF_1234 → araddr_o 0x8000_0000; rdata_o 0xFFFF_FF80; LBU gives 0x0000_0080.
3. LHU, araddr 0x8000_0002, roff 2, same word → rdata_o 0x0000_80FF; LH gives 0xFFFF_80FF; LW at offset 0 gives 0x80FF_1234.
4. SB to 0x8000_0001, wdata 0x0000_00AB, wstrb 0x02, with awready 2 cycles late and wready immediate → wvalid_o drops first, awvalid_o holds; wdata_o 0x0000_AB00, wstrb_o 0x2; one B handshake; valid_o with err_o=0.
5. Backpressure and errors: ready_i held 0 for 4 cycles → valid_o/rdata_o stable. rresp 2'b10 → err_o=1. No rvalid for TIMEOUT cycles → err_o=1, rready_o drops.
6. Non-memory request → valid_o the next cycle, rdata_o 0; no AXI activity.

Source files
------------

// File: rtl/lsu_axi_ctrl.sv
// lsu_axi_ctrl: one AXI4-Lite data-memory access per accepted LSU request, with load extension and store alignment
module lsu_axi_ctrl #(
    parameter int TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        valid_i,
    output logic        ready_o,
    input  logic [1:0]  inst_type_i,
    input  logic [2:0]  lsu_op_i,
    input  logic [31:0] araddr_i,
    input  logic [31:0] roff_i,
    input  logic [31:0] awaddr_i,
    input  logic [31:0] wdata_i,
    input  logic [7:0]  wstrb_i,
    output logic        valid_o,
    input  logic        ready_i,
    output logic [31:0] rdata_o,
    output logic        err_o,
    output logic        arvalid_o,
    input  logic        arready_i,
    output logic [31:0] araddr_o,
    input  logic        rvalid_i,
    output logic        rready_o,
    input  logic [31:0] rdata_i,
    input  logic [1:0]  rresp_i,
    output logic        awvalid_o,
    input  logic        awready_i,
    output logic [31:0] awaddr_o,
    output logic        wvalid_o,
    input  logic        wready_i,
    output logic [31:0] wdata_o,
    output logic [3:0]  wstrb_o,
    input  logic        bvalid_i,
    output logic        bready_o,
    input  logic [1:0]  bresp_i
);
    // inst_type: 1 = load, 2 = store, anything else is a non-memory op
    localparam logic [1:0] INST_LOAD  = 2'd1;
    localparam logic [1:0] INST_STORE = 2'd2;
    // lsu_op: LB=0 LBU=1 LH=2 LHU=3 LW=4 SB=5 SH=6 SW=7
    localparam logic [2:0] LB  = 3'd0;
    localparam logic [2:0] LBU = 3'd1;
    localparam logic [2:0] LH  = 3'd2;
    localparam logic [2:0] LHU = 3'd3;

    typedef enum logic [2:0] {IDLE, RADDR, RDATA, WREQ, WRESP, DONE} state_t;

    state_t      state;
    logic [31:0] addr, wdata, cnt, shifted, load_val;
    logic [2:0]  op;
    logic [1:0]  roff;
    logic [3:0]  wstrb;
    logic        aw_done, w_done, aw_hs, w_hs, both, advance, busy, expired;
    logic        unused_bits;

    assign unused_bits = ^{roff_i[31:2], wstrb_i[7:4]};

    assign ready_o   = (state == IDLE) && !rst;
    assign valid_o   = state == DONE;
    assign arvalid_o = state == RADDR;
    assign araddr_o  = arvalid_o ? {addr[31:2], 2'b00} : '0;
    assign rready_o  = state == RDATA;
    assign awvalid_o = (state == WREQ) && !aw_done;
    assign wvalid_o  = (state == WREQ) && !w_done;
    assign awaddr_o  = (state == WREQ) ? {addr[31:2], 2'b00} : '0;
    assign wdata_o   = (state == WREQ) ? wdata << {addr[1:0], 3'b000} : '0;
    assign wstrb_o   = (state == WREQ) ? wstrb : '0;
    assign bready_o  = state == WRESP;

    assign aw_hs   = awvalid_o && awready_i;
    assign w_hs    = wvalid_o && wready_i;
    assign both    = (aw_done || aw_hs) && (w_done || w_hs);
    assign busy    = state inside {RADDR, RDATA, WREQ, WRESP};
    assign advance = (state == RADDR && arready_i) || (state == RDATA && rvalid_i) ||
                     (state == WREQ && both) || (state == WRESP && bvalid_i);
    assign expired = (TIMEOUT != 0) && (cnt == 32'(TIMEOUT - 1));

    // Load data: bring the addressed byte/half down to bit 0, then extend per op
    always_comb begin
        shifted  = rdata_i >> {roff, 3'b000};
        load_val = op == LB  ? {{24{shifted[7]}}, shifted[7:0]} :
                   op == LBU ? {24'b0, shifted[7:0]} :
                   op == LH  ? {{16{shifted[15]}}, shifted[15:0]} :
                   op == LHU ? {16'b0, shifted[15:0]} : shifted;
    end

    // Request sequencer; a stalled handshake past TIMEOUT cycles aborts to DONE with an error
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            cnt     <= '0;
            op      <= '0;
            roff    <= '0;
            addr    <= '0;
            wdata   <= '0;
            wstrb   <= '0;
            aw_done <= 1'b0;
            w_done  <= 1'b0;
            rdata_o <= '0;
            err_o   <= 1'b0;
        end else begin
            cnt <= (busy && !advance) ? cnt + 32'd1 : '0;
            case (state)
                IDLE: if (valid_i) begin
                    op      <= lsu_op_i;
                    roff    <= roff_i[1:0];
                    addr    <= (inst_type_i == INST_LOAD) ? araddr_i : awaddr_i;
                    wdata   <= wdata_i;
                    wstrb   <= wstrb_i[3:0];
                    aw_done <= 1'b0;
                    w_done  <= 1'b0;
                    rdata_o <= '0;
                    err_o   <= 1'b0;
                    state   <= (inst_type_i == INST_LOAD) ? RADDR : (inst_type_i == INST_STORE) ? WREQ : DONE;
                end
                RADDR: if (arready_i) state <= RDATA;
                RDATA: if (rvalid_i) begin
                    rdata_o <= load_val;
                    err_o   <= rresp_i != 2'b00;
                    state   <= DONE;
                end
                WREQ: begin
                    aw_done <= aw_done || aw_hs;
                    w_done  <= w_done || w_hs;
                    if (both) state <= WRESP;
                end
                WRESP: if (bvalid_i) begin
                    err_o <= bresp_i != 2'b00;
                    state <= DONE;
                end
                DONE: if (ready_i) state <= IDLE;
                default: state <= IDLE;
            endcase
            if (busy && !advance && expired) begin
                state   <= DONE;
                rdata_o <= '0;
                err_o   <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_lsu_axi_ctrl.sv
// tb_lsu_axi_ctrl: directed and randomized LSU requests against a spec-level result model and AXI slave driver
module tb_lsu_axi_ctrl;
    localparam int T = 6;
    localparam logic [1:0] LOAD = 2'd1, STORE = 2'd2, OTHER = 2'd0;
    localparam logic [2:0] LB = 3'd0, LBU = 3'd1, LH = 3'd2, LHU = 3'd3, LW = 3'd4, SB = 3'd5, SH = 3'd6, SW = 3'd7;

    logic clk = 1'b0, rst = 1'b1;
    logic valid_i = 0, ready_o, valid_o, ready_i = 0, err_o;
    logic [1:0] inst_type_i = 0;
    logic [2:0] lsu_op_i = 0;
    logic [31:0] araddr_i = 0, roff_i = 0, awaddr_i = 0, wdata_i = 0, rdata_o;
    logic [7:0] wstrb_i = 0;
    logic arvalid_o, arready_i = 0, rvalid_i = 0, rready_o, awvalid_o, awready_i = 0;
    logic wvalid_o, wready_i = 0, bvalid_i = 0, bready_o;
    logic [31:0] araddr_o, rdata_i = 0, awaddr_o, wdata_o;
    logic [1:0] rresp_i = 0, bresp_i = 0;
    logic [3:0] wstrb_o;

    int errors = 0, checks = 0;
    logic [32:0] expq[$];

    lsu_axi_ctrl #(.TIMEOUT(T)) dut (
        .clk(clk), .rst(rst), .valid_i(valid_i), .ready_o(ready_o), .inst_type_i(inst_type_i),
        .lsu_op_i(lsu_op_i), .araddr_i(araddr_i), .roff_i(roff_i), .awaddr_i(awaddr_i),
        .wdata_i(wdata_i), .wstrb_i(wstrb_i), .valid_o(valid_o), .ready_i(ready_i),
        .rdata_o(rdata_o), .err_o(err_o), .arvalid_o(arvalid_o), .arready_i(arready_i),
        .araddr_o(araddr_o), .rvalid_i(rvalid_i), .rready_o(rready_o), .rdata_i(rdata_i),
        .rresp_i(rresp_i), .awvalid_o(awvalid_o), .awready_i(awready_i), .awaddr_o(awaddr_o),
        .wvalid_o(wvalid_o), .wready_i(wready_i), .wdata_o(wdata_o), .wstrb_o(wstrb_o),
        .bvalid_i(bvalid_i), .bready_o(bready_o), .bresp_i(bresp_i)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] model_load(input logic [2:0] op, input logic [1:0] off, input logic [31:0] word);
        logic [31:0] s;
        s = word >> (int'(off) * 8);
        case (op)
            LB:      return 32'($signed(s[7:0]));
            LBU:     return 32'(s[7:0]);
            LH:      return 32'($signed(s[15:0]));
            LHU:     return 32'(s[15:0]);
            default: return s;
        endcase
    endfunction

    function automatic logic [31:0] model_wdata(input logic [31:0] wd, input logic [1:0] lo);
        return wd << (int'(lo) * 8);
    endfunction

    // Result checker: every cycle valid_o is up, rdata_o/err_o must equal the oldest expected result
    always @(negedge clk) begin
        #1;
        if (!rst && valid_o) begin
            chk("result pending", 32'(expq.size() != 0), 1);
            if (expq.size() != 0) begin
                chk("rdata_o", rdata_o, expq[0][31:0]);
                chk("err_o", err_o, 32'(expq[0][32]));
                if (ready_i) void'(expq.pop_front());
            end
        end
    end

    task automatic issue(input logic [1:0] typ, input logic [2:0] op, input logic [31:0] a,
                         input logic [1:0] off, input logic [31:0] wd, input logic [7:0] ws);
        chk("ready_o idle", 32'(ready_o), 1);
        valid_i = 1; inst_type_i = typ; lsu_op_i = op; roff_i = {30'b0, off};
        araddr_i = (typ == LOAD) ? a : $urandom;
        awaddr_i = (typ == LOAD) ? $urandom : a;
        wdata_i = wd; wstrb_i = ws;
        @(negedge clk);
        valid_i = 0; araddr_i = $urandom; awaddr_i = $urandom; wdata_i = $urandom; wstrb_i = 8'($urandom);
        roff_i = $urandom; lsu_op_i = 3'($urandom);
    endtask

    task automatic finish_txn(input int bp);
        chk("valid_o latency", 32'(valid_o), 1);
        for (int n = 0; n <= bp; n++) begin
            chk("axi idle in done", {27'b0, arvalid_o, rready_o, awvalid_o, wvalid_o, bready_o}, 0);
            chk("valid_o held", 32'(valid_o), 1);
            ready_i = (n == bp);
            @(negedge clk);
        end
        ready_i = 0;
        chk("valid_o cleared", 32'(valid_o), 0);
    endtask

    task automatic run_load(input logic [2:0] op, input logic [31:0] a, input logic [1:0] off, input logic [31:0] word,
                            input logic [1:0] resp, input int dar, input int dr, input int bp);
        expq.push_back((dar >= T || dr >= T) ? {1'b1, 32'h0} : {resp != 2'b00, model_load(op, off, word)});
        issue(LOAD, op, a, off, $urandom, 8'($urandom));
        for (int k = 0; k <= dar && k < T; k++) begin
            chk("arvalid_o", 32'(arvalid_o), 1);
            chk("araddr_o", araddr_o, a & 32'hFFFF_FFFC);
            arready_i = (k == dar);
            @(negedge clk);
        end
        arready_i = 0;
        if (dar < T) begin
            for (int k = 0; k <= dr && k < T; k++) begin
                chk("rready_o", 32'(rready_o), 1);
                chk("arvalid_o dropped", 32'(arvalid_o), 0);
                rvalid_i = (k == dr);
                rdata_i = (k == dr) ? word : $urandom;
                rresp_i = (k == dr) ? resp : 2'($urandom);
                @(negedge clk);
            end
        end
        rvalid_i = 0;
        finish_txn(bp);
    endtask

    task automatic run_store(input logic [2:0] op, input logic [31:0] a, input logic [31:0] wd, input logic [7:0] ws,
                             input logic [1:0] resp, input int da, input int dw, input int db, input int bp);
        int m;
        m = (da > dw) ? da : dw;
        expq.push_back((m >= T || db >= T) ? {1'b1, 32'h0} : {resp != 2'b00, 32'h0});
        issue(STORE, op, a, 2'($urandom), wd, ws);
        for (int k = 0; k <= m && k < T; k++) begin
            chk("awvalid_o", 32'(awvalid_o), 32'(k <= da));
            chk("wvalid_o", 32'(wvalid_o), 32'(k <= dw));
            if (k <= da) chk("awaddr_o", awaddr_o, a & 32'hFFFF_FFFC);
            if (k <= dw) begin
                chk("wdata_o", wdata_o, model_wdata(wd, a[1:0]));
                chk("wstrb_o", 32'(wstrb_o), 32'(ws[3:0]));
            end
            awready_i = (k == da);
            wready_i = (k == dw);
            @(negedge clk);
        end
        awready_i = 0; wready_i = 0;
        if (m < T) begin
            for (int k = 0; k <= db && k < T; k++) begin
                chk("bready_o", 32'(bready_o), 1);
                chk("aw/w dropped", {30'b0, awvalid_o, wvalid_o}, 0);
                bvalid_i = (k == db);
                bresp_i = (k == db) ? resp : 2'($urandom);
                @(negedge clk);
            end
        end
        bvalid_i = 0;
        finish_txn(bp);
    endtask

    function automatic int rdelay();
        return ($urandom_range(0, 9) == 0) ? T + $urandom_range(0, 1) : $urandom_range(0, 3);
    endfunction

    initial begin
        chk("pin LB", model_load(LB, 2'd3, 32'h80FF_1234), 32'hFFFF_FF80);
        chk("pin LBU", model_load(LBU, 2'd3, 32'h80FF_1234), 32'h0000_0080);
        chk("pin LHU", model_load(LHU, 2'd2, 32'h80FF_1234), 32'h0000_80FF);
        chk("pin LH", model_load(LH, 2'd2, 32'h80FF_1234), 32'hFFFF_80FF);
        chk("pin LW", model_load(LW, 2'd0, 32'h80FF_1234), 32'h80FF_1234);
        chk("pin SB wdata", model_wdata(32'h0000_00AB, 2'd1), 32'h0000_AB00);

        repeat (2) @(negedge clk);
        chk("reset ready_o", 32'(ready_o), 0);
        chk("reset outputs", {28'b0, valid_o, err_o, arvalid_o, awvalid_o}, 0);
        chk("reset rdata_o", rdata_o, 0);
        rst = 0;
        @(negedge clk);
        chk("ready_o after reset", 32'(ready_o), 1);

        issue(LOAD, LB, 32'h8000_0003, 2'd3, 0, 0);
        chk("arvalid_o before reset", 32'(arvalid_o), 1);
        rst = 1;
        #1;
        chk("arvalid_o async drop", 32'(arvalid_o), 0);
        chk("ready_o in reset", 32'(ready_o), 0);
        @(negedge clk);
        rst = 0;
        #1;
        chk("ready_o after mid-read reset", 32'(ready_o), 1);
        chk("valid_o after mid-read reset", 32'(valid_o), 0);
        @(negedge clk);

        run_load(LB, 32'h8000_0003, 2'd3, 32'h80FF_1234, 2'b00, 0, 0, 0);
        run_load(LBU, 32'h8000_0003, 2'd3, 32'h80FF_1234, 2'b00, 0, 0, 0);
        run_load(LHU, 32'h8000_0002, 2'd2, 32'h80FF_1234, 2'b00, 0, 0, 0);
        run_load(LH, 32'h8000_0002, 2'd2, 32'h80FF_1234, 2'b00, 0, 0, 0);
        run_load(LW, 32'h8000_0000, 2'd0, 32'h80FF_1234, 2'b00, 0, 0, 4);
        run_store(SB, 32'h8000_0001, 32'h0000_00AB, 8'h02, 2'b00, 2, 0, 0, 0);
        run_store(SW, 32'h8000_0010, 32'hDEAD_BEEF, 8'h00, 2'b00, 0, 3, 1, 0);
        run_load(LW, 32'h8000_0004, 2'd0, 32'h1234_5678, 2'b10, 1, 1, 0);
        run_load(LW, 32'h8000_0008, 2'd0, 32'h1234_5678, 2'b00, 0, T, 2);
        run_store(SH, 32'h8000_0002, 32'h0000_BEEF, 8'h0C, 2'b00, T, 0, 0, 0);
        issue(OTHER, LW, 32'h0, 2'd0, 32'h0, 8'h0);
        expq.push_back(33'h0);
        finish_txn(0);

        for (int i = 0; i < 200; i++) begin
            logic [31:0] a;
            int sel;
            a = $urandom;
            sel = $urandom_range(0, 9);
            if (sel < 5)
                run_load(3'($urandom_range(0, 4)), a, a[1:0], $urandom, ($urandom_range(0, 4) == 0) ? 2'($urandom) : 2'b00,
                         rdelay(), rdelay(), $urandom_range(0, 3));
            else if (sel < 9)
                run_store(3'($urandom_range(5, 7)), a, $urandom, 8'($urandom), ($urandom_range(0, 4) == 0) ? 2'($urandom) : 2'b00,
                          rdelay(), rdelay(), rdelay(), $urandom_range(0, 3));
            else begin
                expq.push_back(33'h0);
                issue(($urandom_range(0, 1) == 0) ? 2'd0 : 2'd3, 3'($urandom), a, 2'($urandom), $urandom, 8'($urandom));
                finish_txn($urandom_range(0, 3));
            end
        end

        repeat (3) @(negedge clk);
        chk("results left unconsumed", expq.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
